// File: rtl/vram_pkg.sv
// Shared definitions for the Zeus VRAM read arbiter.
//   prio_mode_e  : arbitration policy selector (fixed priority / round-robin)
//   VRAM_ADDR_W  : default VRAM word address width
//   VRAM_DATA_W  : default VRAM data width
//   idx_w()      : width of a channel index, never narrower than 1 bit
package vram_pkg;

  typedef enum logic {
    PRIO_FIXED = 1'b0,
    PRIO_RR    = 1'b1
  } prio_mode_e;

  localparam int unsigned VRAM_ADDR_W = 15;
  localparam int unsigned VRAM_DATA_W = 32;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vram_arbiter_rr_if.sv
// Bus bundle between the video read fetchers, the arbiter and the VRAM read port.
//   vram_addr  : read address to VRAM (arbiter -> VRAM)
//   vram_rd    : read enable (arbiter -> VRAM)
//   vram_data  : read data, valid RD_LAT cycles after its address (VRAM -> arbiter)
//   vrf_addr   : packed per-channel request addresses, channel k at [k*ADDR_W +: ADDR_W]
//   vrf_strobe : per-channel request strobes
//   vrf_gnt    : one-hot combinational grant
//   vrf_ack    : one-hot ack, aligned with vrf_data
//   vrf_data   : shared read data bus, qualified by vrf_ack
// Modports: master = arbiter side, slave = fetcher/VRAM side.
interface vram_arbiter_rr_if
  import vram_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ADDR_W = VRAM_ADDR_W,
  parameter int unsigned DATA_W = VRAM_DATA_W
);

  logic [ADDR_W-1:0]        vram_addr;
  logic                     vram_rd;
  logic [DATA_W-1:0]        vram_data;
  logic [NUM_CH*ADDR_W-1:0] vrf_addr;
  logic [NUM_CH-1:0]        vrf_strobe;
  logic [NUM_CH-1:0]        vrf_gnt;
  logic [NUM_CH-1:0]        vrf_ack;
  logic [DATA_W-1:0]        vrf_data;

  modport master (
    output vram_addr, vram_rd, vrf_gnt, vrf_ack, vrf_data,
    input  vram_data, vrf_addr, vrf_strobe
  );

  modport slave (
    input  vram_addr, vram_rd, vrf_gnt, vrf_ack, vrf_data,
    output vram_data, vrf_addr, vrf_strobe
  );

endinterface

// File: rtl/vram_arbiter_rr_pick.sv
// rr_pick: combinational rotating priority picker.
//   req_i   : request vector
//   ptr_i   : index of the highest-priority channel (tie to 0 for fixed priority)
//   gnt_o   : one-hot grant
//   idx_o   : index of the granted channel
//   valid_o : a request was granted
module rr_pick #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IDX_W  = 2
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              valid_o
);

  // Scan ptr_i, ptr_i+1, ... modulo NUM_CH; the first active request wins.
  always_comb begin
    int unsigned pos;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    pos     = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pos = (i + ptr_i) % NUM_CH;
      if (!valid_o && req_i[pos]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(pos);
      end
    end
    if (valid_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/vram_arbiter_rr.sv
// VRAM read arbiter: grants one of NUM_CH video read fetchers per cycle onto a
// single synchronous VRAM read port, and returns a one-hot ack aligned with
// the read data RD_LAT cycles later.
//   clk_i   : system/video clock
//   rst_ni  : asynchronous active-low reset
//   arb_bus : master side of vram_arbiter_rr_if (VRAM port + fetcher bus)
// Parameters: NUM_CH (2..16), ADDR_W, DATA_W, RD_LAT (1..4), PRIO_MODE.
module vram_arbiter_rr
  import vram_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned ADDR_W    = VRAM_ADDR_W,
  parameter int unsigned DATA_W    = VRAM_DATA_W,
  parameter int unsigned RD_LAT    = 1,
  parameter prio_mode_e  PRIO_MODE = PRIO_FIXED
) (
  input logic               clk_i,
  input logic               rst_ni,
  vram_arbiter_rr_if.master arb_bus
);

  localparam int unsigned IW = idx_w(NUM_CH);

  logic [IW-1:0]     rr_ptr_q;
  logic [IW-1:0]     rr_ptr_d;
  logic [IW-1:0]     pick_ptr;
  logic [NUM_CH-1:0] gnt;
  logic [IW-1:0]     gnt_idx;
  logic              gnt_vld;
  logic [ADDR_W-1:0] addr_mux;
  logic [NUM_CH-1:0] ack;
  logic [DATA_W-1:0] rd_data;

  // Grant-tracking pipeline: stage 0 holds this cycle's grant, the last stage
  // lines up with the VRAM data for that grant.
  logic [RD_LAT-1:0] pipe_vld_q;
  logic [IW-1:0]     pipe_idx_q [RD_LAT];

  // Fixed priority is the rotating picker with its start pointer pinned to 0.
  assign pick_ptr = (PRIO_MODE == PRIO_RR) ? rr_ptr_q : '0;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IW)
  ) u_pick (
    .req_i   (arb_bus.vrf_strobe),
    .ptr_i   (pick_ptr),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .valid_o (gnt_vld)
  );

  always_comb begin
    addr_mux = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (gnt[k]) addr_mux = arb_bus.vrf_addr[k*ADDR_W +: ADDR_W];
    end
  end

  assign arb_bus.vram_addr = addr_mux;
  assign arb_bus.vram_rd   = gnt_vld;
  assign arb_bus.vrf_gnt   = gnt;

  // Pointer moves to the channel after the winner, wrapping at NUM_CH-1.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_vld) begin
      rr_ptr_d = (gnt_idx == IW'(NUM_CH - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_vld_q <= '0;
      for (int unsigned s = 0; s < RD_LAT; s++) pipe_idx_q[s] <= '0;
    end else begin
      pipe_vld_q[0] <= gnt_vld;
      pipe_idx_q[0] <= gnt_idx;
      for (int unsigned s = 1; s < RD_LAT; s++) begin
        pipe_vld_q[s] <= pipe_vld_q[s-1];
        pipe_idx_q[s] <= pipe_idx_q[s-1];
      end
    end
  end

  // Ack is a decode of the last pipeline register only, so it is glitch-free
  // and cleared by reset together with the valids.
  always_comb begin
    ack = '0;
    if (pipe_vld_q[RD_LAT-1]) ack[pipe_idx_q[RD_LAT-1]] = 1'b1;
  end

  assign arb_bus.vrf_ack  = ack;
  assign rd_data          = arb_bus.vram_data;
  assign arb_bus.vrf_data = rd_data;

endmodule

// File: tb/tb_vram_arbiter_rr.sv
// Directed self-checking bench for vram_arbiter_rr. Four instances share the
// request stimulus: A fixed/RD_LAT=1, B round-robin/RD_LAT=1,
// C round-robin/RD_LAT=3, D round-robin/RD_LAT=2 with its own extra reset.
module tb_vram_arbiter_rr;
  import vram_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 15;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            rst_d;
  logic            rst_nd;
  logic [N-1:0]    strb;
  logic [N*AW-1:0] addrs;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  vram_arbiter_rr_if #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) ifa ();
  vram_arbiter_rr_if #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) ifb ();
  vram_arbiter_rr_if #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) ifc ();
  vram_arbiter_rr_if #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) ifd ();

  // VRAM model: data word is a fixed tag OR'd with the address.
  function automatic logic [DW-1:0] vmem(input logic [AW-1:0] a);
    return 32'hD000_0000 | {17'd0, a};
  endfunction

  logic [AW-1:0]        apa;
  logic [AW-1:0]        apb;
  logic [2:0][AW-1:0]   apc;
  logic [1:0][AW-1:0]   apd;

  always_ff @(posedge clk) begin
    apa <= ifa.vram_addr;
    apb <= ifb.vram_addr;
    apc <= {apc[1:0], ifc.vram_addr};
    apd <= {apd[0], ifd.vram_addr};
  end

  assign rst_nd = rst_n & rst_d;

  assign ifa.vrf_strobe = strb;
  assign ifb.vrf_strobe = strb;
  assign ifc.vrf_strobe = strb;
  assign ifd.vrf_strobe = strb;
  assign ifa.vrf_addr   = addrs;
  assign ifb.vrf_addr   = addrs;
  assign ifc.vrf_addr   = addrs;
  assign ifd.vrf_addr   = addrs;
  assign ifa.vram_data  = vmem(apa);
  assign ifb.vram_data  = vmem(apb);
  assign ifc.vram_data  = vmem(apc[2]);
  assign ifd.vram_data  = vmem(apd[1]);

  vram_arbiter_rr #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .PRIO_MODE(PRIO_FIXED))
    u_a (.clk_i(clk), .rst_ni(rst_n), .arb_bus(ifa));
  vram_arbiter_rr #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .PRIO_MODE(PRIO_RR))
    u_b (.clk_i(clk), .rst_ni(rst_n), .arb_bus(ifb));
  vram_arbiter_rr #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .PRIO_MODE(PRIO_RR))
    u_c (.clk_i(clk), .rst_ni(rst_n), .arb_bus(ifc));
  vram_arbiter_rr #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .PRIO_MODE(PRIO_RR))
    u_d (.clk_i(clk), .rst_ni(rst_nd), .arb_bus(ifd));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int k, input logic [AW-1:0] a);
    addrs[k*AW +: AW] = a;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    strb  = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  logic [3:0]  exp_g [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
  logic [31:0] exp_d [8] = '{32'hD000_0AAA, 32'hD000_0100, 32'hD000_0222, 32'hD000_0300,
                             32'hD000_0AAA, 32'hD000_0100, 32'hD000_0222, 32'hD000_0300};

  initial begin
    rst_n = 1'b0;
    rst_d = 1'b1;
    strb  = '0;
    addrs = '0;
    set_addr(0, 15'h0AAA);
    set_addr(1, 15'h0100);
    set_addr(2, 15'h0222);
    set_addr(3, 15'h0300);

    // Reset state
    cyc();
    cyc();
    #1;
    chk("rst_ack_a", 32'(ifa.vrf_ack), 32'h0);
    chk("rst_ack_b", 32'(ifb.vrf_ack), 32'h0);
    chk("rst_ack_c", 32'(ifc.vrf_ack), 32'h0);
    chk("rst_ack_d", 32'(ifd.vrf_ack), 32'h0);
    chk("rst_rd_a",  32'(ifa.vram_rd), 32'h0);
    chk("rst_addr_a", 32'(ifa.vram_addr), 32'h0);
    rst_n = 1'b1;

    // Fixed priority: lowest index wins
    cyc(); strb = 4'b1010; #1;
    chk("fix_gnt0",  32'(ifa.vrf_gnt),   32'h2);
    chk("fix_addr0", 32'(ifa.vram_addr), 32'h0100);
    chk("fix_rd0",   32'(ifa.vram_rd),   32'h1);
    cyc(); strb = 4'b1111; #1;
    chk("fix_ack0",  32'(ifa.vrf_ack),   32'h2);
    chk("fix_data0", ifa.vrf_data,       32'hD000_0100);
    chk("fix_gnt1",  32'(ifa.vrf_gnt),   32'h1);
    chk("fix_addr1", 32'(ifa.vram_addr), 32'h0AAA);
    cyc(); strb = 4'b1000; #1;
    chk("fix_ack1",  32'(ifa.vrf_ack),   32'h1);
    chk("fix_gnt3",  32'(ifa.vrf_gnt),   32'h8);
    chk("fix_addr3", 32'(ifa.vram_addr), 32'h0300);
    cyc(); strb = 4'b0000; #1;
    chk("fix_ack3",  32'(ifa.vrf_ack),   32'h8);
    chk("fix_data3", ifa.vrf_data,       32'hD000_0300);
    chk("fix_gnt_none", 32'(ifa.vrf_gnt), 32'h0);

    // Round-robin, all channels strobing
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(); strb = 4'b1111; #1;
      chk("rr_gnt", 32'(ifb.vrf_gnt), 32'(exp_g[i]));
      if (i > 0) begin
        chk("rr_ack",  32'(ifb.vrf_ack), 32'(exp_g[i-1]));
        chk("rr_data", ifb.vrf_data,     exp_d[i-1]);
      end
    end
    cyc(); strb = 4'b0000; #1;
    chk("rr_ack_last",  32'(ifb.vrf_ack), 32'h8);
    chk("rr_data_last", ifb.vrf_data,     32'hD000_0300);

    // Round-robin pointer holds across idle cycles and wraps
    do_reset();
    cyc(); strb = 4'b0100; #1;
    chk("hold_gnt2", 32'(ifb.vrf_gnt), 32'h4);
    for (int i = 0; i < 3; i++) begin
      cyc(); strb = 4'b0000; #1;
      chk("hold_idle_gnt", 32'(ifb.vrf_gnt), 32'h0);
      chk("hold_idle_rd",  32'(ifb.vram_rd), 32'h0);
    end
    cyc(); strb = 4'b0101; #1;
    chk("hold_wrap_gnt0", 32'(ifb.vrf_gnt),   32'h1);
    chk("hold_wrap_addr", 32'(ifb.vram_addr), 32'h0AAA);
    cyc(); #1;
    chk("hold_next_gnt2", 32'(ifb.vrf_gnt),   32'h4);
    chk("hold_next_addr", 32'(ifb.vram_addr), 32'h0222);
    cyc(); strb = 4'b0010; #1;
    chk("single_gnt_a", 32'(ifb.vrf_gnt), 32'h2);
    cyc(); #1;
    chk("single_gnt_b", 32'(ifb.vrf_gnt), 32'h2);
    cyc(); #1;
    chk("single_gnt_c", 32'(ifb.vrf_gnt), 32'h2);

    // RD_LAT=3: three back-to-back reads on ch1, strobe dropped at T+3
    do_reset();
    cyc(); strb = 4'b0010; set_addr(1, 15'h0010); #1;
    chk("lat3_gnt",   32'(ifc.vrf_gnt),   32'h2);
    chk("lat3_addr0", 32'(ifc.vram_addr), 32'h0010);
    chk("lat3_ack_t0", 32'(ifc.vrf_ack),  32'h0);
    cyc(); set_addr(1, 15'h0011); #1;
    chk("lat3_addr1", 32'(ifc.vram_addr), 32'h0011);
    chk("lat3_ack_t1", 32'(ifc.vrf_ack),  32'h0);
    cyc(); set_addr(1, 15'h0012); #1;
    chk("lat3_addr2", 32'(ifc.vram_addr), 32'h0012);
    chk("lat3_ack_t2", 32'(ifc.vrf_ack),  32'h0);
    cyc(); strb = 4'b0000; #1;
    chk("lat3_ack_t3",  32'(ifc.vrf_ack), 32'h2);
    chk("lat3_data_t3", ifc.vrf_data,     32'hD000_0010);
    chk("lat3_gnt_t3",  32'(ifc.vrf_gnt), 32'h0);
    cyc(); #1;
    chk("lat3_ack_t4",  32'(ifc.vrf_ack), 32'h2);
    chk("lat3_data_t4", ifc.vrf_data,     32'hD000_0011);
    cyc(); #1;
    chk("lat3_ack_t5",  32'(ifc.vrf_ack), 32'h2);
    chk("lat3_data_t5", ifc.vrf_data,     32'hD000_0012);
    cyc(); #1;
    chk("lat3_ack_t6",  32'(ifc.vrf_ack), 32'h0);
    set_addr(1, 15'h0100);

    // Reset mid-flight with RD_LAT=2
    do_reset();
    cyc(); strb = 4'b0001; #1;
    chk("mid_gnt0", 32'(ifd.vrf_gnt), 32'h1);
    cyc(); strb = 4'b0000; rst_d = 1'b0; #1;
    chk("mid_ack_t1", 32'(ifd.vrf_ack), 32'h0);
    cyc(); #1;
    chk("mid_ack_t2", 32'(ifd.vrf_ack), 32'h0);
    rst_d = 1'b1;
    cyc(); strb = 4'b1111; #1;
    chk("mid_ptr0_gnt", 32'(ifd.vrf_gnt), 32'h1);
    chk("mid_ack_t3",   32'(ifd.vrf_ack), 32'h0);
    cyc(); strb = 4'b0000; #1;
    chk("mid_ack_g1", 32'(ifd.vrf_ack), 32'h0);
    cyc(); #1;
    chk("mid_ack_g2",  32'(ifd.vrf_ack), 32'h1);
    chk("mid_data_g2", ifd.vrf_data,     32'hD000_0AAA);

    // Idle: nothing requested for 5 cycles
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(); strb = 4'b0000; #1;
      chk("idle_rd",   32'(ifa.vram_rd),   32'h0);
      chk("idle_addr", 32'(ifa.vram_addr), 32'h0);
      chk("idle_ack_a", 32'(ifa.vrf_ack),  32'h0);
      chk("idle_ack_b", 32'(ifb.vrf_ack),  32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
